// File: rtl/pcs_tx_am_ins.sv
// Multi-lane PCS TX alignment-marker inserter with per-lane BIP generation.
// One registered output slot; with AM_EN=0 it collapses to a plain register slice.
module pcs_tx_am_ins #(
  parameter int                   LANE_N = 4,
  parameter int                   DATA_W = 64,
  parameter int                   HEAD_W = 2,
  parameter int                   AM_EN  = 1,
  parameter int                   AM_GAP = 16383,
  parameter logic [LANE_N*24-1:0] AM_ENC = 96'h3D79A2_9B65C5_E6C4F0_477690
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [LANE_N*HEAD_W-1:0]   head_i,
  input  logic [LANE_N*DATA_W-1:0]   data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       marker_v_o,
  output logic [LANE_N*HEAD_W-1:0]   head_o,
  output logic [LANE_N*DATA_W-1:0]   data_o
);

  localparam int HW = LANE_N * HEAD_W;
  localparam int DW = LANE_N * DATA_W;

  logic          valid_q, valid_d;
  logic          marker_q, marker_d;
  logic [HW-1:0] head_q, head_d;
  logic [DW-1:0] data_q, data_d;
  logic          adv;

  assign adv        = ~valid_q | ready_i;
  assign valid_o    = valid_q;
  assign marker_v_o = marker_q;
  assign head_o     = head_q;
  assign data_o     = data_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q  <= 1'b0;
      marker_q <= 1'b0;
      head_q   <= '0;
      data_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      marker_q <= marker_d;
      head_q   <= head_d;
      data_q   <= data_d;
    end
  end

  generate
    if (AM_EN != 0) begin : g_am
      localparam int CNT_W = (AM_GAP < 2) ? 1 : $clog2(AM_GAP + 1);

      logic [CNT_W-1:0]    cnt_q, cnt_d;
      logic [LANE_N*8-1:0] bip_q, bip_d;
      logic [LANE_N*8-1:0] mk_par, in_par;
      logic [HW-1:0]       mk_head;
      logic [DW-1:0]       mk_data;

      // Bit i of the parity folds payload bit i of every byte; header bits land in 3 and 4.
      function automatic logic [7:0] blk_par(input logic [1:0] h, input logic [63:0] d);
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < 8; j++) p = p ^ d[8*j +: 8];
        p[3] = p[3] ^ h[0];
        p[4] = p[4] ^ h[1];
        return p;
      endfunction

      always_comb begin
        mk_head = '0;
        mk_data = '0;
        mk_par  = '0;
        in_par  = '0;
        for (int l = 0; l < LANE_N; l++) begin
          mk_head[l*HEAD_W +: 2]  = 2'b01;
          mk_data[l*DATA_W +: 64] = {~bip_q[l*8 +: 8],
                                     ~AM_ENC[l*24+16 +: 8],
                                     ~AM_ENC[l*24+8 +: 8],
                                     ~AM_ENC[l*24 +: 8],
                                     bip_q[l*8 +: 8],
                                     AM_ENC[l*24 +: 24]};
          mk_par[l*8 +: 8] = blk_par(2'b01, mk_data[l*DATA_W +: 64]);
          in_par[l*8 +: 8] = blk_par(head_i[l*HEAD_W +: 2], data_i[l*DATA_W +: 64]);
        end
      end

      // A marker takes priority whenever the gap counter has run out, even with valid_i low.
      always_comb begin
        valid_d  = valid_q;
        marker_d = marker_q;
        head_d   = head_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        bip_d    = bip_q;
        if (adv) begin
          if (cnt_q == '0) begin
            valid_d  = 1'b1;
            marker_d = 1'b1;
            head_d   = mk_head;
            data_d   = mk_data;
            cnt_d    = CNT_W'(AM_GAP);
            bip_d    = mk_par;
          end else if (valid_i) begin
            valid_d  = 1'b1;
            marker_d = 1'b0;
            head_d   = head_i;
            data_d   = data_i;
            cnt_d    = cnt_q - CNT_W'(1);
            bip_d    = bip_q ^ in_par;
          end else begin
            valid_d  = 1'b0;
            marker_d = 1'b0;
          end
        end
      end

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          cnt_q <= '0;
          bip_q <= '0;
        end else begin
          cnt_q <= cnt_d;
          bip_q <= bip_d;
        end
      end

      assign ready_o = adv & (cnt_q != '0);
    end else begin : g_pt
      always_comb begin
        valid_d  = valid_q;
        marker_d = 1'b0;
        head_d   = head_q;
        data_d   = data_q;
        if (adv) begin
          valid_d = valid_i;
          if (valid_i) begin
            head_d = head_i;
            data_d = data_i;
          end
        end
      end

      assign ready_o = adv;
    end
  endgenerate

endmodule

// File: tb/tb_pcs_tx_am_ins.sv
// Self-checking bench for pcs_tx_am_ins: fixed vectors for marker/BIP/pass-through corners,
// plus randomized traffic against a stream-level reference model on a short-gap instance.
module tb_pcs_tx_am_ins;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Default-parameter instance: first marker contents and asynchronous reset.
  logic         d_valid_i, d_ready_o, d_valid_o, d_ready_i, d_marker;
  logic [7:0]   d_head_i, d_head_o;
  logic [255:0] d_data_i, d_data_o;

  pcs_tx_am_ins u_def (
    .clk(clk), .nreset(nreset),
    .valid_i(d_valid_i), .ready_o(d_ready_o), .head_i(d_head_i), .data_i(d_data_i),
    .valid_o(d_valid_o), .ready_i(d_ready_i), .marker_v_o(d_marker),
    .head_o(d_head_o), .data_o(d_data_o)
  );

  // Four lanes with a short gap: randomized traffic against the reference model.
  logic         g_valid_i, g_ready_o, g_valid_o, g_ready_i, g_marker;
  logic [7:0]   g_head_i, g_head_o;
  logic [255:0] g_data_i, g_data_o;

  pcs_tx_am_ins #(.AM_GAP(4)) u_gap (
    .clk(clk), .nreset(nreset),
    .valid_i(g_valid_i), .ready_o(g_ready_o), .head_i(g_head_i), .data_i(g_data_i),
    .valid_o(g_valid_o), .ready_i(g_ready_i), .marker_v_o(g_marker),
    .head_o(g_head_o), .data_o(g_data_o)
  );

  // Single lane, gap of two: BIP accumulation, bubbles and stalls by hand-computed vectors.
  logic         b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_marker;
  logic [1:0]   b_head_i, b_head_o;
  logic [63:0]  b_data_i, b_data_o;

  pcs_tx_am_ins #(.LANE_N(1), .AM_GAP(2), .AM_ENC(24'h477690)) u_bip (
    .clk(clk), .nreset(nreset),
    .valid_i(b_valid_i), .ready_o(b_ready_o), .head_i(b_head_i), .data_i(b_data_i),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .marker_v_o(b_marker),
    .head_o(b_head_o), .data_o(b_data_o)
  );

  // Marker-free single-lane register slice.
  logic         p_valid_i, p_ready_o, p_valid_o, p_ready_i, p_marker;
  logic [1:0]   p_head_i, p_head_o;
  logic [63:0]  p_data_i, p_data_o;

  pcs_tx_am_ins #(.LANE_N(1), .AM_EN(0), .AM_GAP(4), .AM_ENC(24'h477690)) u_pt (
    .clk(clk), .nreset(nreset),
    .valid_i(p_valid_i), .ready_o(p_ready_o), .head_i(p_head_i), .data_i(p_data_i),
    .valid_o(p_valid_o), .ready_i(p_ready_i), .marker_v_o(p_marker),
    .head_o(p_head_o), .data_o(p_data_o)
  );

  typedef struct packed {
    logic        v;
    logic        r;
    logic [1:0]  h;
    logic [63:0] d;
    logic        exp_ready;
    logic        exp_valid;
    logic        exp_marker;
    logic [1:0]  exp_head;
    logic [63:0] exp_data;
  } vec_t;

  vec_t bip_tab[9];
  vec_t pt_tab[6];

  // Reference model state for the short-gap instance.
  localparam int GAP = 4;
  logic [95:0]  enc4 = 96'h3D79A2_9B65C5_E6C4F0_477690;
  int           loaded;
  logic         m_valid, m_marker;
  logic [7:0]   m_head;
  logic [255:0] m_data;
  logic [7:0]   acc[4];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // BIP parity straight from the 66-bit block numbering b0..b65.
  function automatic logic [7:0] refPar(input logic [1:0] h, input logic [63:0] d);
    logic [65:0] b;
    logic [7:0]  p;
    b = {d, h};
    p = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) p[i] = p[i] ^ b[2 + i + 8*j];
    p[3] = p[3] ^ b[0];
    p[4] = p[4] ^ b[1];
    return p;
  endfunction

  function automatic logic [63:0] refMarker(input logic [23:0] enc, input logic [7:0] bip);
    logic [7:0]  by[8];
    logic [63:0] r;
    by[0] = enc[7:0];
    by[1] = enc[15:8];
    by[2] = enc[23:16];
    by[3] = bip;
    for (int j = 0; j < 4; j++) by[j+4] = ~by[j];
    r = '0;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = by[j];
    return r;
  endfunction

  task automatic doReset();
    @(negedge clk);
    nreset    = 1'b0;
    d_valid_i = 1'b0; d_ready_i = 1'b1;
    g_valid_i = 1'b0; g_ready_i = 1'b1;
    b_valid_i = 1'b0; b_ready_i = 1'b1;
    p_valid_i = 1'b0; p_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input bit pt, input int idx);
    string tag;
    tag = $sformatf("%s[%0d]", pt ? "pt" : "bip", idx);
    @(negedge clk);
    if (pt) begin
      p_valid_i = v.v; p_ready_i = v.r; p_head_i = v.h; p_data_i = v.d;
    end else begin
      b_valid_i = v.v; b_ready_i = v.r; b_head_i = v.h; b_data_i = v.d;
    end
    #1;
    checkOutput({tag, ".ready_o"}, 256'(pt ? p_ready_o : b_ready_o), 256'(v.exp_ready));
    @(posedge clk);
    #1;
    checkOutput({tag, ".valid_o"}, 256'(pt ? p_valid_o : b_valid_o), 256'(v.exp_valid));
    checkOutput({tag, ".marker_v_o"}, 256'(pt ? p_marker : b_marker), 256'(v.exp_marker));
    checkOutput({tag, ".head_o"}, 256'(pt ? p_head_o : b_head_o), 256'(v.exp_head));
    checkOutput({tag, ".data_o"}, 256'(pt ? p_data_o : b_data_o), 256'(v.exp_data));
  endtask

  // One cycle on the short-gap instance: check current outputs, then advance the model.
  task automatic stepGap(input logic v, input logic r);
    logic        adv, next_marker;
    logic [63:0] mk;
    @(negedge clk);
    g_valid_i = v;
    g_ready_i = r;
    g_head_i  = 8'($urandom);
    for (int k = 0; k < 8; k++) g_data_i[32*k +: 32] = $urandom;
    #1;
    checkOutput("gap.valid_o", 256'(g_valid_o), 256'(m_valid));
    checkOutput("gap.marker_v_o", 256'(g_marker), 256'(m_marker));
    if (m_valid) begin
      checkOutput("gap.head_o", 256'(g_head_o), 256'(m_head));
      checkOutput("gap.data_o", g_data_o, m_data);
    end
    adv         = !m_valid || r;
    next_marker = (loaded % (GAP + 1)) == 0;
    checkOutput("gap.ready_o", 256'(g_ready_o), 256'(adv && !next_marker));
    if (adv) begin
      if (next_marker) begin
        for (int l = 0; l < 4; l++) begin
          mk = refMarker(enc4[l*24 +: 24], acc[l]);
          m_data[l*64 +: 64] = mk;
          m_head[l*2 +: 2]   = 2'b01;
          acc[l]             = refPar(2'b01, mk);
        end
        m_valid  = 1'b1;
        m_marker = 1'b1;
        loaded++;
      end else if (v) begin
        for (int l = 0; l < 4; l++)
          acc[l] = acc[l] ^ refPar(g_head_i[l*2 +: 2], g_data_i[l*64 +: 64]);
        m_head   = g_head_i;
        m_data   = g_data_i;
        m_valid  = 1'b1;
        m_marker = 1'b0;
        loaded++;
      end else begin
        m_valid  = 1'b0;
        m_marker = 1'b0;
      end
    end
  endtask

  initial begin
    nreset    = 1'b1;
    d_valid_i = 1'b0; d_ready_i = 1'b1; d_head_i = '0; d_data_i = '0;
    g_valid_i = 1'b0; g_ready_i = 1'b1; g_head_i = '0; g_data_i = '0;
    b_valid_i = 1'b0; b_ready_i = 1'b1; b_head_i = '0; b_data_i = '0;
    p_valid_i = 1'b0; p_ready_i = 1'b1; p_head_i = '0; p_data_i = '0;

    bip_tab[0] = '{1'b0, 1'b1, 2'b00, 64'h0,                  1'b0, 1'b1, 1'b1, 2'b01, 64'hFFB8896F_00477690};
    bip_tab[1] = '{1'b1, 1'b1, 2'b10, 64'h1,                  1'b1, 1'b1, 1'b0, 2'b10, 64'h1};
    bip_tab[2] = '{1'b1, 1'b1, 2'b10, 64'h0,                  1'b1, 1'b1, 1'b0, 2'b10, 64'h0};
    bip_tab[3] = '{1'b1, 1'b1, 2'b01, 64'h5,                  1'b0, 1'b1, 1'b1, 2'b01, 64'hF6B8896F_09477690};
    bip_tab[4] = '{1'b1, 1'b0, 2'b11, 64'hAA,                 1'b0, 1'b1, 1'b1, 2'b01, 64'hF6B8896F_09477690};
    bip_tab[5] = '{1'b1, 1'b1, 2'b01, 64'h0102,               1'b1, 1'b1, 1'b0, 2'b01, 64'h0102};
    bip_tab[6] = '{1'b0, 1'b1, 2'b10, 64'h7777,               1'b1, 1'b0, 1'b0, 2'b01, 64'h0102};
    bip_tab[7] = '{1'b1, 1'b1, 2'b00, 64'hFF00000000000000,   1'b1, 1'b1, 1'b0, 2'b00, 64'hFF00000000000000};
    bip_tab[8] = '{1'b0, 1'b1, 2'b11, 64'h1234,               1'b0, 1'b1, 1'b1, 2'b01, 64'h03B8896F_FC477690};

    pt_tab[0] = '{1'b1, 1'b1, 2'b01, 64'hA5A5_0000_1111_2222, 1'b1, 1'b1, 1'b0, 2'b01, 64'hA5A5_0000_1111_2222};
    pt_tab[1] = '{1'b1, 1'b0, 2'b10, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b1, 1'b0, 2'b01, 64'hA5A5_0000_1111_2222};
    pt_tab[2] = '{1'b0, 1'b1, 2'b11, 64'hCCCC_CCCC_CCCC_CCCC, 1'b1, 1'b0, 1'b0, 2'b01, 64'hA5A5_0000_1111_2222};
    pt_tab[3] = '{1'b1, 1'b0, 2'b10, 64'hDDDD_0123_4567_89AB, 1'b1, 1'b1, 1'b0, 2'b10, 64'hDDDD_0123_4567_89AB};
    pt_tab[4] = '{1'b1, 1'b1, 2'b11, 64'hEEEE_FEDC_BA98_7654, 1'b1, 1'b1, 1'b0, 2'b11, 64'hEEEE_FEDC_BA98_7654};
    pt_tab[5] = '{1'b0, 1'b0, 2'b00, 64'h0,                   1'b0, 1'b1, 1'b0, 2'b11, 64'hEEEE_FEDC_BA98_7654};

    // Reset state and first marker with default parameters.
    doReset();
    @(negedge clk);
    #1;
    checkOutput("def.reset.valid_o", 256'(d_valid_o), 256'(1'b0));
    checkOutput("def.reset.marker_v_o", 256'(d_marker), 256'(1'b0));
    checkOutput("def.reset.head_o", 256'(d_head_o), 256'(8'h00));
    checkOutput("def.reset.data_o", d_data_o, 256'(0));
    checkOutput("def.reset.ready_o", 256'(d_ready_o), 256'(1'b0));
    @(posedge clk);
    #1;
    checkOutput("def.m1.valid_o", 256'(d_valid_o), 256'(1'b1));
    checkOutput("def.m1.marker_v_o", 256'(d_marker), 256'(1'b1));
    checkOutput("def.m1.head_o", 256'(d_head_o), 256'(8'h55));
    checkOutput("def.m1.lane0", 256'(d_data_o[63:0]), 256'(64'hFFB8896F_00477690));
    checkOutput("def.m1.lane3", 256'(d_data_o[255:192]), 256'(64'hFFC2865D_003D79A2));
    checkOutput("def.m1.ready_o", 256'(d_ready_o), 256'(1'b1));

    // A data slot, then an asynchronous reset between clock edges.
    d_valid_i = 1'b1;
    d_head_i  = 8'hAA;
    d_data_i  = {4{64'h0123_4567_89AB_CDEF}};
    @(posedge clk);
    #1;
    checkOutput("def.d1.marker_v_o", 256'(d_marker), 256'(1'b0));
    checkOutput("def.d1.data_o", d_data_o, {4{64'h0123_4567_89AB_CDEF}});
    #2 nreset = 1'b0;
    #1;
    checkOutput("def.arst.valid_o", 256'(d_valid_o), 256'(1'b0));
    checkOutput("def.arst.marker_v_o", 256'(d_marker), 256'(1'b0));
    checkOutput("def.arst.head_o", 256'(d_head_o), 256'(8'h00));
    checkOutput("def.arst.data_o", d_data_o, 256'(0));
    checkOutput("gap.arst.valid_o", 256'(g_valid_o), 256'(1'b0));
    @(posedge clk);
    #2 nreset = 1'b1;
    #1;
    checkOutput("def.rst2.ready_o", 256'(d_ready_o), 256'(1'b0));
    @(posedge clk);
    #1;
    checkOutput("def.rst2.marker_v_o", 256'(d_marker), 256'(1'b1));
    checkOutput("def.rst2.lane0", 256'(d_data_o[63:0]), 256'(64'hFFB8896F_00477690));
    d_valid_i = 1'b0;

    // BIP accumulation, stall and bubble on the single-lane gap-2 instance.
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(bip_tab[i], 1'b0, i);

    // Marker-free pass-through.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(pt_tab[i], 1'b1, i);
    checkOutput("pt.marker_v_o", 256'(p_marker), 256'(1'b0));

    // Randomized and structured traffic on the short-gap instance.
    doReset();
    loaded   = 0;
    m_valid  = 1'b0;
    m_marker = 1'b0;
    m_head   = '0;
    m_data   = '0;
    for (int l = 0; l < 4; l++) acc[l] = '0;
    for (int i = 0; i < 30; i++) stepGap(1'b1, 1'b1);
    for (int i = 0; i < 4; i++)  stepGap(1'b1, 1'b1);
    for (int i = 0; i < 3; i++)  stepGap(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) stepGap(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) stepGap(i[0] == 1'b0, 1'b1);
    for (int i = 0; i < 400; i++)
      stepGap($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pcs_tx_am_ins.md
# pcs_tx_am_ins

Parametrised alignment-marker inserter and BIP generator for the multi-lane PCS transmit path. It sits between the scrambler output and the per-lane gearboxes. It generalises the fixed 4-lane marker stage in three ways:
- parametrised lane count, marker gap and per-lane marker encodings;
- full valid/ready handshake on both sides;
- a marker-free pass-through mode for 10GBASE-R.

All lanes are transferred together in one slot.

## Interface
Parameters:
- `LANE_N`, 4, number of PCS lanes (1..20).
- `DATA_W`, 64, payload bits per lane block. The BIP mapping requires 64.
- `HEAD_W`, 2, sync header bits per lane. The BIP mapping requires 2.
- `AM_EN`, 1, 1 inserts markers; 0 makes the block a plain register slice.
- `AM_GAP`, 16383, data blocks per lane between two markers (≥1).
- `AM_ENC`, 96'h3D79A2_9B65C5_E6C4F0_477690, `LANE_N*24` bits. `{M2,M1,M0}` for lane l sits at `[l*24+:24]`.

Ports:
- `clk`  in  1  PCS clock.
- `nreset`  in  1  asynchronous active-low reset.
- `valid_i`  in  1  upstream block set valid.
- `ready_o`  out  1  upstream block set accepted this cycle when `valid_i & ready_o`.
- `head_i`  in  `LANE_N*HEAD_W`  sync headers, lane l at `[l*2+:2]`.
- `data_i`  in  `LANE_N*DATA_W`  scrambled payloads.
- `valid_o`  out  1  output slot valid.
- `ready_i`  in  1  gearbox accept.
- `marker_v_o`  out  1  the current output slot is an alignment marker.
- `head_o`  out  `LANE_N*HEAD_W`  registered headers.
- `data_o`  out  `LANE_N*DATA_W`  registered payloads.

## Operation
Definitions:
- `adv = ~valid_o | ready_i`. This is the output register load enable.
- `cnt` is the remaining data blocks before the next marker. Its width is `$clog2(AM_GAP+1)`; it resets to 0.
- `bip[l]`, 8 bits per lane, resets to 0.

When `AM_EN=1`:
- `ready_o = adv & (cnt != 0)`. This is combinational.
- **Marker load** (`adv & cnt==0`): the marker is loaded regardless of `valid_i`. Then `valid_o<=1`, `marker_v_o<=1`, `cnt<=AM_GAP`.
  - Lane l: `head_o=2'b01` (control sync header).
  - Lane l payload bytes 0..7 = M0, M1, M2, `bip[l]`, ~M0, ~M1, ~M2, ~`bip[l]`. Byte j is `data_o[l*64+8j+:8]`.
- **Data load** (`adv & cnt!=0 & valid_i`): `head_o/data_o <= head_i/data_i`, `valid_o<=1`, `marker_v_o<=0`, `cnt<=cnt-1`.
- **Bubble** (`adv & cnt!=0 & ~valid_i`): `valid_o<=0`, `marker_v_o<=0`, `cnt` unchanged. Data and head hold.
- **Stall** (`~adv`): all registers hold.

BIP, per lane, uses 66-bit block bits b0..b65:
- b0 = head[0], b1 = head[1], b(k+2) = data[k].
- `par(B)[i]` = XOR of b(2+i+8j) for j = 0..7.
- `par(B)[3]` additionally XORs b0; `par(B)[4]` additionally XORs b1.
- On a data load: `bip[l] <= bip[l] ^ par(block)`.
- On a marker load: the marker carries the current `bip[l]`, then `bip[l] <= par(marker block)`. Each BIP therefore covers the previous marker plus all data since it.

When `AM_EN=0`:
- `ready_o = adv`. `marker_v_o` is constant 0.
- `cnt` and `bip` are removed; the block is a one-deep register slice.

## Timing
- Reset (asynchronous, immediate): `valid_o=0`, `marker_v_o=0`, `head_o=0`, `data_o=0`, `cnt=0`, `bip=0`.
- After reset with `AM_EN=1`, `ready_o=0` in the first cycle. The first slot is always a marker, with BIP3=0x00 and BIP7=0xFF.
- Latency: 1 cycle from an accepted input to `valid_o`.
- Throughput: one set per cycle, except one marker slot every `AM_GAP+1` slots, during which `ready_o=0`.
- Outputs are stable while `valid_o & ~ready_i`.
- `ready_o` depends combinationally on `ready_i`. There is no combinational path from `valid_i`.
- A reset mid-stream discards the output register and restarts the marker sequence.

## Test plan
- **Reset, first marker.** Default parameters, release reset, `ready_i=1`.
  - Cycle 1: `valid_o=1`, `marker_v_o=1`.
  - Lane0 `data_o = 64'hFFB8896F_00477690`, `head_o = 2'b01`.
  - Lane3 bytes = A2 79 3D 00 5D 86 C2 FF.
- **Gap count.** `AM_GAP=4`, `valid_i=1` constant, `ready_i=1`.
  - `marker_v_o` is high every 5th valid output.
  - `ready_o` is low exactly in the cycles where a marker is loaded.
- **BIP.** `AM_GAP=2`, lane0 after the first marker.
  - Send head 2'b10 with data `64'h1`, then head 2'b10 with data `64'h0`.
  - Second marker lane0: byte3 = 0x09, byte7 = 0xF6.
- **Backpressure.** Hold `ready_i=0` for 3 cycles while a data slot is valid.
  - `data_o`, `head_o`, `valid_o` and `marker_v_o` stay unchanged and `ready_o=0`.
  - On release, there are no lost or duplicated blocks and the marker spacing is preserved.
- **Bubbles.** `valid_i` toggles 1/0 with `ready_i=1`.
  - `cnt` decrements only on accepted blocks, so exactly `AM_GAP` data blocks separate markers.
- **Pass-through and async reset.**
  - `AM_EN=0`, `LANE_N=1`: output equals input one cycle later and `marker_v_o=0` always.
  - Assert `nreset` mid-stream: outputs clear immediately, without waiting for a `clk` edge.
